cdb_result_queue: RTL and testbench
===================================

CDB_RESULT_QUEUE -- requirements
Module: cdb_result_queue

Purpose: per-functional-unit result buffer on the requester side of the common data bus (CDB). It holds completed results, raises a request, presents the head entry, and pops that entry when the CDB grants it.

Interface
REQ-001 Parameter WIDTH, default 101, meaning width of one result word (ALU/branch CDB port format).
REQ-002 Parameter DEPTH, default 4, meaning number of entries; SHALL be a power of two, 2 or greater.
REQ-003 clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous discard of all queued results (mispredict recovery).
REQ-006 in_valid  input  1  functional unit presents a result this cycle.
REQ-007 in_data  input  WIDTH  result word from the functional unit.
REQ-008 full  output  1  high when count equals DEPTH; the functional unit SHALL stall while full.
REQ-009 cdb_req  output  1  request to the CDB arbiter.
REQ-010 cdb_dout  output  WIDTH  head-of-queue word, driven to the CDB data port.
REQ-011 cdb_granted  input  1  arbiter grant; combinational from cdb_req in the arbiter.
REQ-012 count  output  log2(DEPTH)+1  number of valid entries.
REQ-013 overflow  output  1  sticky error flag, set when a push is lost.

Function
REQ-014 Storage SHALL be a circular buffer with a read pointer and a write pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-015 cdb_req SHALL equal (count != 0); it SHALL be decoded from registered state only, never from in_valid.
REQ-016 cdb_dout SHALL equal the entry at the read pointer whenever count != 0.
REQ-017 cdb_dout SHALL be all zeros when count == 0.
REQ-018 pop SHALL equal cdb_granted AND cdb_req.
REQ-019 On pop, the read pointer SHALL increment at the same edge on which the arbiter captures cdb_dout.
REQ-020 cdb_granted while cdb_req is low SHALL be ignored.
REQ-021 push SHALL equal in_valid AND (NOT full OR pop).
REQ-022 On push, in_data SHALL be written at the write pointer, and the write pointer SHALL increment.
REQ-023 Latency: a result pushed at edge N SHALL appear on cdb_req and cdb_dout after edge N; there is no same-cycle bypass.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; this applies when full and when count is 1.
REQ-025 At count 1 with simultaneous push and pop, the new word SHALL be the head after the edge.
REQ-026 count SHALL update as count + push - pop.
REQ-027 in_valid while full with no pop SHALL drop the word, leave all state unchanged, and set overflow.
REQ-028 overflow SHALL be cleared only by rst; flush SHALL NOT clear it.
REQ-029 Ordering SHALL be strict FIFO; results SHALL leave in arrival order.
REQ-030 flush SHALL set both pointers and count to 0 at the edge, overriding push and pop in the same cycle.
REQ-031 The functional unit is responsible for not asserting in_valid with flush; any such word SHALL be discarded.
REQ-032 If cdb_granted and flush are high together, the arbiter still captures the head word; this is the required behaviour and is the issuer's responsibility to squash.
REQ-033 Contents of storage entries SHALL NOT need reset; only pointers, count and overflow are reset.

Reset
REQ-034 While rst is high at an edge, the pointers SHALL be set to 0, count to 0 and overflow to 0.
REQ-035 While rst is high, cdb_req SHALL be 0, full SHALL be 0 and cdb_dout SHALL be 0 on the cycle after the edge.
REQ-036 rst SHALL take priority over flush, push and pop.
REQ-037 rst asserted mid-operation SHALL discard all entries; the first push after rst deasserts SHALL become the head.

Verification
REQ-038 Reset, then push 0x1, 0x2, 0x3 on three consecutive cycles with cdb_granted held low -> count goes 1, 2, 3; cdb_req goes high one cycle after the first push; cdb_dout stays 0x1.
REQ-039 From the state of REQ-038, assert cdb_granted for three cycles -> cdb_dout reads 0x1, 0x2, 0x3 on successive cycles; count reaches 0; cdb_req and cdb_dout drop to 0.
REQ-040 Fill with 0xA, 0xB, 0xC, 0xD, then push 0xE with no grant -> full=1, overflow=1, contents unchanged. Then push 0xF with cdb_granted high -> count stays 4; subsequent pops return 0xB, 0xC, 0xD, 0xF.
REQ-041 Push and pop every cycle for 10 cycles starting at count 1 -> count stays 1; the pointers wrap; output sequence equals the input sequence delayed by one entry.
REQ-042 With count 3, assert flush together with in_valid and cdb_granted -> count=0 and cdb_req=0 next cycle; overflow is unchanged.
REQ-043 Assert cdb_granted with an empty queue, and assert rst with count 2 -> no state change from the grant; after rst, count=0 and full=0.

Source files
------------

// File: rtl/cdb_result_queue.sv
// Per-functional-unit result buffer feeding the common data bus.
// It holds completed results in order and presents the head entry with a request until the arbiter grants it.
module cdb_result_queue #(
    parameter int WIDTH = 101,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     full,
    output logic                     cdb_req,
    output logic [WIDTH-1:0]         cdb_dout,
    input  logic                     cdb_granted,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;
    logic             lost;

    // The request and the head word depend only on registered state, so the arbiter never sees in_valid combinationally.
    assign full     = (count == CNT_W'(DEPTH));
    assign cdb_req  = (count != '0);
    assign cdb_dout = cdb_req ? mem[rd_ptr] : '0;

    assign pop  = cdb_granted & cdb_req;
    assign push = in_valid & (~full | pop);
    assign lost = in_valid & full & ~pop & ~flush;

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (lost) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_result_queue.sv
// Directed self-checking bench for cdb_result_queue.
// Inputs change 1 ns after each rising edge, and outputs are sampled at that same point.
module tb_cdb_result_queue;

    localparam int WIDTH = 101;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   full;
    logic                   cdb_req;
    logic [WIDTH-1:0]       cdb_dout;
    logic                   cdb_granted;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;

    int n_checks = 0;
    int n_errors = 0;

    cdb_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .full        (full),
        .cdb_req     (cdb_req),
        .cdb_dout    (cdb_dout),
        .cdb_granted (cdb_granted),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic g);
        in_valid    = v;
        in_data     = d;
        cdb_granted = g;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        step();
        check("rst_req",   cdb_req,  0);
        check("rst_full",  full,     0);
        check("rst_dout",  cdb_dout, 0);
        check("rst_count", count,    0);
        check("rst_ovf",   overflow, 0);
        step();
        rst = 1'b0;

        // Three pushes, no grant: head stays at the first word
        drive(1'b1, 1, 1'b0);
        check("pre_push_req", cdb_req, 0);
        step();
        check("p1_count", count, 1);
        check("p1_req",   cdb_req, 1);
        check("p1_dout",  cdb_dout, 1);
        drive(1'b1, 2, 1'b0); step();
        check("p2_count", count, 2);
        check("p2_dout",  cdb_dout, 1);
        drive(1'b1, 3, 1'b0); step();
        check("p3_count", count, 3);
        check("p3_dout",  cdb_dout, 1);

        // Drain with grant held
        drive(1'b0, '0, 1'b1);
        check("d0_dout", cdb_dout, 1);
        step();
        check("d1_dout",  cdb_dout, 2);
        check("d1_count", count, 2);
        step();
        check("d2_dout",  cdb_dout, 3);
        check("d2_count", count, 1);
        step();
        check("d3_count", count, 0);
        check("d3_req",   cdb_req, 0);
        check("d3_dout",  cdb_dout, 0);

        // Fill, overflow, then push+pop while full
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 'hA + i, 1'b0);
            step();
        end
        check("fill_full",  full, 1);
        check("fill_count", count, 4);
        check("fill_ovf",   overflow, 0);
        drive(1'b1, 'hE, 1'b0); step();
        check("ovf_flag",  overflow, 1);
        check("ovf_count", count, 4);
        check("ovf_dout",  cdb_dout, 'hA);
        drive(1'b1, 'hF, 1'b1); step();
        check("fullpp_count", count, 4);
        check("fullpp_full",  full, 1);
        check("fullpp_dout",  cdb_dout, 'hB);
        drive(1'b0, '0, 1'b1);
        step(); check("fp_dout_c", cdb_dout, 'hC);
        step(); check("fp_dout_d", cdb_dout, 'hD);
        step(); check("fp_dout_f", cdb_dout, 'hF);
        step();
        check("fp_count", count, 0);
        check("fp_ovf_sticky", overflow, 1);

        // Streaming at count 1 across pointer wrap
        drive(1'b1, 'h10, 1'b0); step();
        check("s_count0", count, 1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 'h11 + i, 1'b1);
            check($sformatf("s_dout%0d", i), cdb_dout, 'h10 + i);
            step();
            check($sformatf("s_count%0d", i + 1), count, 1);
        end
        check("s_last", cdb_dout, 'h1A);
        drive(1'b0, '0, 1'b1); step();
        check("s_empty", count, 0);

        // Flush at count 3 with push and grant
        drive(1'b1, 'h21, 1'b0); step();
        drive(1'b1, 'h22, 1'b0); step();
        drive(1'b1, 'h23, 1'b0); step();
        check("fl_pre_count", count, 3);
        flush = 1'b1;
        drive(1'b1, 'h99, 1'b1);
        check("fl_capture", cdb_dout, 'h21);
        step();
        flush = 1'b0;
        check("fl_count", count, 0);
        check("fl_req",   cdb_req, 0);
        check("fl_ovf",   overflow, 1);
        drive(1'b1, 'h31, 1'b0); step();
        check("fl_head", cdb_dout, 'h31);
        check("fl_head_count", count, 1);
        drive(1'b0, '0, 1'b1); step();
        check("fl_drain", count, 0);

        // Grant while empty is ignored
        drive(1'b0, '0, 1'b1); step();
        check("eg_count", count, 0);
        check("eg_req",   cdb_req, 0);
        drive(1'b1, 'h41, 1'b0); step();
        check("eg_head", cdb_dout, 'h41);
        drive(1'b1, 'h42, 1'b0); step();
        check("eg_count2", count, 2);

        // Reset mid-operation beats push and grant
        rst = 1'b1;
        drive(1'b1, 'h77, 1'b1);
        step();
        rst = 1'b0;
        check("mr_count", count, 0);
        check("mr_full",  full, 0);
        check("mr_req",   cdb_req, 0);
        check("mr_dout",  cdb_dout, 0);
        check("mr_ovf",   overflow, 0);
        drive(1'b1, 'h51, 1'b0); step();
        check("mr_head",  cdb_dout, 'h51);
        check("mr_count1", count, 1);
        drive(1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
